rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one resource between 8 requesters.
- Encodes the winning request to a 3-bit index plus a valid flag, using the same index/valid convention as the team's 8-to-3 encoder.
- Holds a grant until the owner releases it, then rotates priority past the last owner.
- Sits in front of any shared datapath, such as a bus port or shared ALU, that must serve one requester at a time.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 in this revision, not overridable.
- IDX_W, 3, width of the grant index; equals log2(N_REQ).
- TIMEOUT_CYCLES, 16, maximum grant hold in cycles; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit i high means requester i wants the resource.
- done  input  1  the current owner releases the grant this cycle.
- gnt  output  8  one-hot grant, registered; all zeros when no grant.
- gnt_idx  output  3  index of the granted requester, registered; 0 when no grant.
- gnt_valid  output  1  a grant is active, registered.
- timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=7 (last owner), hold counter=0. All outputs clear immediately, including mid-grant.
- State machine, two states:
  - IDLE: if |req at a clock edge, pick the winner W, load gnt=1<<W, gnt_idx=W, gnt_valid=1, and go to GRANT. Otherwise stay in IDLE.
  - GRANT: release when done=1, or when req[gnt_idx]=0 (requester withdrew). On release: ptr=gnt_idx, all gnt outputs clear, go to IDLE.
- Grant latency: a request sampled in IDLE at edge t produces gnt_valid=1 after edge t. Release sampled at edge t produces gnt_valid=0 after edge t.
- The IDLE cycle after each release is mandatory. The minimum grant period is 2 cycles (1 granted + 1 dead).
- Round-robin pick: search order is ptr+1, ptr+2, …, ptr+8, all mod 8. The first set req bit wins. The last owner has the lowest priority.
- Wrap-around: with ptr=7 the search starts at bit 0; with ptr=6 the order is 7,0,1,…,6.
- Requests that change during GRANT do not affect the current owner.
- A single persistent requester is re-granted after each dead cycle.
- done=1 in IDLE is ignored.
- done and a withdrawn request in the same cycle count as one release.
- gnt is always one-hot or zero; gnt_idx always matches gnt.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on grant and increments every GRANT cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 without a release, the arbiter forces a release: ptr=gnt_idx, go to IDLE, timeout=1 for exactly that following cycle.
  - A normal release on the same cycle takes precedence: timeout stays 0.
- Undefined: no counter is built, timeout is tied to 0, and a grant is held indefinitely.

Decomposition:
- Package arb_pkg holds:
  - localparams N_REQ=8 and IDX_W=3;
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - typedef logic [IDX_W-1:0] arb_idx_t.
- One sub-module, rr_pick8, is combinational:
  - inputs: req[7:0] and ptr[2:0];
  - operation: rotates req right by ptr+1, applies an LSB-first priority encode, then rotates the index back;
  - outputs: win_idx[2:0] and any_req.
- The top level keeps the FSM, pointer, output registers and the optional counter.

Test Plan:
- Reset check: assert rst mid-grant with req=8'hFF → gnt=0, gnt_valid=0, timeout=0 asynchronously. After release, the first grant is idx 0.
- Rotation: req=8'hFF held, done pulsed on each grant cycle → grant sequence is idx 0,1,…,7,0, each gnt_valid high 1 cycle, low 1 cycle.
- Fairness / wrap-around: ptr=5 (after idx 5 released), req=8'b0010_0001 → idx 0 granted before 5, with gnt=8'h01. Next grant is idx 5, with gnt=8'h20.
- Withdraw and ignored inputs: grant idx 3, then drop req[3] with done=0 → gnt_valid falls after that edge and ptr=3. done=1 with req=0 in IDLE → no grant.
- Hold stability: grant idx 2 with req=8'h04, then toggle other req bits for 10 cycles with done=0 → gnt stays 8'h04 (timeout build off).
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): req=8'h10, done never asserted → forced release after 4 granted cycles, timeout=1 for one cycle. The grant returns to idx 4 after the dead cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  // Maximum grant hold in cycles when the forced-release build is enabled (legal 2..255)
  localparam int TIMEOUT_CYCLES = 16;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef logic [IDX_W-1:0] arb_idx_t;

endpackage

// File: rtl/rr_pick8.sv
// Round-robin winner select: first set request strictly after ptr, wrapping mod 8.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on win_idx.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  arb_idx_t         ptr,
  output arb_idx_t         win_idx,
  output logic             any_req
);

  logic [IDX_W:0]     shamt;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  arb_idx_t           first;

  // Rotate right by ptr+1 so bit 0 of rot is the highest-priority requester;
  // ptr+1 spans 1..8, hence the extra shift bit.
  assign shamt = {1'b0, ptr} + {{IDX_W{1'b0}}, 1'b1};
  assign dbl   = {req, req} >> shamt;
  assign rot   = dbl[N_REQ-1:0];

  // LSB-first priority encode of the rotated vector
  always_comb begin
    first = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) first = arb_idx_t'(i);
    end
  end

  // Undo the rotation; 3-bit wrap gives the mod-8 arithmetic for free
  assign win_idx = first + ptr + arb_idx_t'(1);
  assign any_req = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters; grant held until done or the owner withdraws.
// Latency: grant registered 1 cycle after request sampled in IDLE; 1 mandatory dead cycle after each release.
// Backpressure: owner holds the resource until it releases; ARB_TIMEOUT_EN adds a forced release after TIMEOUT_CYCLES.
module rr_arbiter8
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  arb_idx_t         idx_q, idx_d;
  arb_idx_t         ptr_q, ptr_d;
  arb_idx_t         win_idx;
  logic             any_req;
  logic             rel;
  logic             frc;
  logic [N_REQ-1:0] win_onehot;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       to_q, to_d;
`endif

  rr_pick8 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  // Voluntary release: explicit done or the owner dropping its request (one release either way)
  assign rel = (state_q == GRANT) && (done || !req[idx_q]);

`ifdef ARB_TIMEOUT_EN
  // Forced release only when no voluntary release is happening this cycle
  assign frc = (state_q == GRANT) && !rel && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign frc = 1'b0;
`endif

  // One-hot decode of the winner
  always_comb begin
    win_onehot = '0;
    win_onehot[win_idx] = 1'b1;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: IDLE grants on any request, GRANT drops back on any release
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)   state_d = GRANT;
      GRANT:   if (rel || frc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the grant, pointer and hold-counter registers
  always_comb begin
    gnt_d = gnt_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d = cnt_q;
    to_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d = win_onehot;
          idx_d = win_idx;
`ifdef ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      GRANT: begin
        if (rel || frc) begin
          gnt_d = '0;
          idx_d = '0;
          ptr_d = idx_q;
`ifdef ARB_TIMEOUT_EN
          to_d  = frc;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        gnt_d = '0;
        idx_d = '0;
      end
    endcase
  end

  // Output and pointer registers; pointer resets to 7 so requester 0 is searched first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q <= '0;
      idx_q <= '0;
      ptr_q <= arb_idx_t'(N_REQ - 1);
    end else begin
      gnt_q <= gnt_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and one-cycle forced-release flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: table of per-cycle vectors plus hand-written reset/hold/timeout sequences.
// Latency: checks sampled on the falling edge after each rising edge.
// Backpressure: n/a.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_total;
  int n_pass;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter8 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic [7:0] r, input logic d, input logic [7:0] g, input logic [2:0] i, input logic v);
    vec_t t;
    t.req = r; t.done = d; t.gnt = g; t.idx = i; t.vld = v;
    vecs.push_back(t);
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int held;
    logic [7:0] oh;
    n_total = 0;
    n_pass  = 0;
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;

    // Rotation with all requesting: 0,1,...,7,0, each grant followed by a dead cycle
    for (int i = 0; i < 9; i++) begin
      oh = 8'h01 << (i % 8);
      add(8'hFF, 1'b0, oh, 3'(i % 8), 1'b1);
      add(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0);
    end
    // ptr=0 -> grant 5 alone, release so ptr=5
    add(8'h20, 1'b0, 8'h20, 3'd5, 1'b1);
    add(8'h20, 1'b1, 8'h00, 3'd0, 1'b0);
    // Wrap-around fairness from ptr=5: 0 before 5, then 5
    add(8'h21, 1'b0, 8'h01, 3'd0, 1'b1);
    add(8'h21, 1'b1, 8'h00, 3'd0, 1'b0);
    add(8'h21, 1'b0, 8'h20, 3'd5, 1'b1);
    add(8'h21, 1'b1, 8'h00, 3'd0, 1'b0);
    // Withdraw: grant 3, drop req[3] with done=0
    add(8'h08, 1'b0, 8'h08, 3'd3, 1'b1);
    add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
    // done in IDLE with no request is ignored
    add(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
    // ptr=3 after withdraw: all requesting -> 4
    add(8'hFF, 1'b0, 8'h10, 3'd4, 1'b1);
    add(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0);
    // done and withdraw together: one release, ptr=5 -> next all-request winner is 6
    add(8'h20, 1'b0, 8'h20, 3'd5, 1'b1);
    add(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
    add(8'hFF, 1'b0, 8'h40, 3'd6, 1'b1);
    add(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0);
    // Single persistent requester re-granted after each dead cycle
    add(8'h02, 1'b0, 8'h02, 3'd1, 1'b1);
    add(8'h02, 1'b1, 8'h00, 3'd0, 1'b0);
    add(8'h02, 1'b0, 8'h02, 3'd1, 1'b1);
    add(8'h02, 1'b1, 8'h00, 3'd0, 1'b0);

    // Reset state
    #1;
    check("reset gnt", 32'(gnt), 32'h0);
    check("reset idx", 32'(gnt_idx), 32'h0);
    check("reset vld", 32'(gnt_valid), 32'h0);
    check("reset timeout", 32'(timeout), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[r]) begin
      req  = vecs[r].req;
      done = vecs[r].done;
      step();
      check($sformatf("row%0d gnt", r), 32'(gnt), 32'(vecs[r].gnt));
      check($sformatf("row%0d idx", r), 32'(gnt_idx), 32'(vecs[r].idx));
      check($sformatf("row%0d vld", r), 32'(gnt_valid), 32'(vecs[r].vld));
      check($sformatf("row%0d timeout", r), 32'(timeout), 32'h0);
    end

    // Hold stability: grant 2, toggle other bits for 10 cycles
    req = 8'h04; done = 1'b0;
    step();
    check("hold grant", 32'(gnt), 32'h04);
    for (int c = 0; c < 10; c++) begin
      req = 8'h04 | (8'($urandom_range(0, 255)) & 8'hFB);
      step();
      check($sformatf("hold c%0d gnt", c), 32'(gnt), 32'h04);
      check($sformatf("hold c%0d idx", c), 32'(gnt_idx), 32'h2);
    end
    req = 8'h00; done = 1'b1;
    step();
    check("hold release", 32'(gnt_valid), 32'h0);

    // Async reset mid-grant
    req = 8'hFF; done = 1'b0;
    step();
    check("pre-reset vld", 32'(gnt_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async rst gnt", 32'(gnt), 32'h0);
    check("async rst vld", 32'(gnt_valid), 32'h0);
    check("async rst timeout", 32'(timeout), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post-reset gnt", 32'(gnt), 32'h01);
    check("post-reset idx", 32'(gnt_idx), 32'h0);
    req = 8'h00; done = 1'b1;
    step();
    check("post-reset release", 32'(gnt_valid), 32'h0);

`ifdef ARB_TIMEOUT_EN
    // Forced release after TIMEOUT_CYCLES granted cycles, one-cycle timeout pulse
    req = 8'h10; done = 1'b0;
    step();
    check("to grant idx", 32'(gnt_idx), 32'h4);
    held = 1;
    while (gnt_valid && held < 300) begin
      step();
      if (gnt_valid) held++;
    end
    check("to hold cycles", 32'(held), 32'(arb_pkg::TIMEOUT_CYCLES));
    check("to pulse", 32'(timeout), 32'h1);
    check("to gnt cleared", 32'(gnt), 32'h0);
    step();
    check("to regrant idx", 32'(gnt_idx), 32'h4);
    check("to regrant vld", 32'(gnt_valid), 32'h1);
    check("to pulse end", 32'(timeout), 32'h0);
    req = 8'h00; done = 1'b1;
    step();
`else
    held = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
